// File: rtl/text_video_ctrl.sv
// Text-mode display controller: raster timing, character/font fetch pipeline,
// 1-bit pixel output with blank/sync and a blinking underline cursor.
module text_video_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 400,
  parameter int V_FP   = 12,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 35,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] char_a,
  input  logic [7:0]  char,
  output logic [11:0] font_a,
  input  logic [7:0]  font_d,
  input  logic        cursor_en,
  input  logic [10:0] cursor_pos,
  output logic        pixel,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        frame
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_W  = 10'(H_VIS);
  localparam logic [8:0]  V_VIS_W  = 9'(V_VIS);
  localparam logic [9:0]  HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [8:0]  VS_START = 9'(V_VIS + V_FP);
  localparam logic [8:0]  VS_END   = 9'(V_VIS + V_FP + V_SYNC);
  localparam logic [10:0] COLS     = 11'(H_VIS / 8);

  typedef struct packed {
    logic [2:0] x;
    logic [3:0] row;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       frm;
    logic       cur;
  } stage_t;

  logic [9:0]  hcnt;
  logic [8:0]  vcnt;
  logic [10:0] row_base;
  logic [4:0]  blink;
  stage_t      pipe [1:4];

  logic        h_end, v_end, vis0;
  logic [10:0] cell0;
  stage_t      s0;

  always_comb begin
    h_end   = (hcnt == H_LAST);
    v_end   = (vcnt == V_LAST);
    vis0    = (hcnt < H_VIS_W) && (vcnt < V_VIS_W);
    cell0   = row_base + {4'd0, hcnt[9:3]};
    s0      = '0;
    s0.x    = hcnt[2:0];
    s0.row  = vcnt[3:0];
    s0.vis  = vis0;
    s0.hs   = (hcnt >= HS_START) && (hcnt < HS_END);
    s0.vs   = (vcnt >= VS_START) && (vcnt < VS_END);
    s0.frm  = (hcnt == 10'd0) && (vcnt == 9'd0);
    // Underline on the last two cell rows, visible during the first half of the blink period.
    s0.cur  = cursor_en && (cell0 == cursor_pos) && (vcnt[3:1] == 3'b111) && !blink[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= '0;
      blink    <= '0;
    end else begin
      hcnt <= h_end ? 10'd0 : hcnt + 10'd1;
      if (h_end) begin
        if (v_end) begin
          vcnt     <= '0;
          row_base <= '0;
          blink    <= blink + 5'd1;
        end else begin
          vcnt <= vcnt + 9'd1;
          if ((vcnt < V_VIS_W) && (vcnt[3:0] == 4'hF))
            row_base <= row_base + COLS;
        end
      end
    end
  end

  // Five-stage fetch pipeline; side-band info travels alongside in pipe[].
  always_ff @(posedge clk) begin
    if (reset) begin
      char_a <= '0;
      font_a <= '0;
      pixel  <= 1'b0;
      blank  <= 1'b1;
      hsync  <= !HS_POL;
      vsync  <= !VS_POL;
      frame  <= 1'b0;
      for (int i = 1; i <= 4; i++) pipe[i] <= '0;
    end else begin
      if (vis0) char_a <= cell0;
      pipe[1] <= s0;
      for (int i = 2; i <= 4; i++) pipe[i] <= pipe[i-1];
      font_a <= {char, pipe[2].row};
      pixel  <= pipe[4].vis & (font_d[3'd7 - pipe[4].x] ^ pipe[4].cur);
      blank  <= !pipe[4].vis;
      hsync  <= pipe[4].hs ? HS_POL : !HS_POL;
      vsync  <= pipe[4].vs ? VS_POL : !VS_POL;
      frame  <= pipe[4].frm;
    end
  end

endmodule

// File: tb/tb_text_video_ctrl.sv
// Directed bench for text_video_ctrl using a reduced raster geometry
// (32x32 visible, 48x36 total, 4x2 text cells) so blink periods fit in a short run.
module tb_text_video_ctrl;

  localparam int HT = 48;
  localparam int FT = 48 * 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] char_a;
  logic [7:0]  char = 8'd0;
  logic [11:0] font_a;
  logic [7:0]  font_d = 8'd0;
  logic        cursor_en = 1'b0;
  logic [10:0] cursor_pos = 11'd0;
  logic        pixel, blank, hsync, vsync, frame;

  logic        font_zero = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  text_video_ctrl #(
    .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .char_a(char_a), .char(char),
    .font_a(font_a), .font_d(font_d), .cursor_en(cursor_en),
    .cursor_pos(cursor_pos), .pixel(pixel), .blank(blank),
    .hsync(hsync), .vsync(vsync), .frame(frame)
  );

  always #5 clk = ~clk;

  // Character RAM (cell k holds code k) and font ROM, both one-cycle latency.
  always @(posedge clk) begin
    char   <= char_a[7:0];
    font_d <= font_zero ? 8'h00 : 8'hA5;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (char_a !== 11'd0 || font_a !== 12'd0 || pixel !== 1'b0 || blank !== 1'b1 ||
        hsync !== 1'b1 || vsync !== 1'b0 || frame !== 1'b0)
      $display("FAIL reset_values: char_a=%0d font_a=%0d pix=%b blank=%b hs=%b vs=%b fr=%b",
               char_a, font_a, pixel, blank, hsync, vsync, frame);
    else n_pass++;
  endtask

  task automatic test_hsync_blank();
    do_reset();
    goto(4);
    n_checks++;
    if (blank !== 1'b1 || frame !== 1'b0) $display("FAIL blank_pre: blank=%b frame=%b want 1 0", blank, frame);
    else n_pass++;
    goto(5);
    n_checks++;
    if (blank !== 1'b0 || frame !== 1'b1) $display("FAIL first_pixel: blank=%b frame=%b want 0 1", blank, frame);
    else n_pass++;
    goto(6);
    n_checks++;
    if (frame !== 1'b0) $display("FAIL frame_width: frame=%b want 0", frame);
    else n_pass++;
    goto(36);
    n_checks++;
    if (blank !== 1'b0) $display("FAIL blank_last_vis: blank=%b want 0", blank);
    else n_pass++;
    goto(37);
    n_checks++;
    if (blank !== 1'b1) $display("FAIL blank_after_vis: blank=%b want 1", blank);
    else n_pass++;
    goto(40);
    n_checks++;
    if (hsync !== 1'b1) $display("FAIL hsync_before: hsync=%b want 1", hsync);
    else n_pass++;
    goto(41);
    n_checks++;
    if (hsync !== 1'b0) $display("FAIL hsync_start: hsync=%b want 0", hsync);
    else n_pass++;
    goto(48);
    n_checks++;
    if (hsync !== 1'b0) $display("FAIL hsync_last: hsync=%b want 0", hsync);
    else n_pass++;
    goto(49);
    n_checks++;
    if (hsync !== 1'b1) $display("FAIL hsync_end: hsync=%b want 1", hsync);
    else n_pass++;
    goto(53);
    n_checks++;
    if (blank !== 1'b0) $display("FAIL blank_line1: blank=%b want 0", blank);
    else n_pass++;
    goto(HT + 41);
    n_checks++;
    if (hsync !== 1'b0) $display("FAIL hsync_period: hsync=%b want 0", hsync);
    else n_pass++;
  endtask

  task automatic test_vsync_frame();
    do_reset();
    goto(33 * HT + 4);
    n_checks++;
    if (vsync !== 1'b0) $display("FAIL vsync_before: vsync=%b want 0", vsync);
    else n_pass++;
    goto(33 * HT + 5);
    n_checks++;
    if (vsync !== 1'b1) $display("FAIL vsync_start: vsync=%b want 1", vsync);
    else n_pass++;
    goto(35 * HT + 4);
    n_checks++;
    if (vsync !== 1'b1) $display("FAIL vsync_last: vsync=%b want 1", vsync);
    else n_pass++;
    goto(35 * HT + 5);
    n_checks++;
    if (vsync !== 1'b0 || frame !== 1'b0) $display("FAIL vsync_end: vsync=%b frame=%b want 0 0", vsync, frame);
    else n_pass++;
    goto(FT + 5);
    n_checks++;
    if (frame !== 1'b1) $display("FAIL frame_period: frame=%b want 1", frame);
    else n_pass++;
  endtask

  task automatic test_char_addr();
    do_reset();
    goto(1);
    n_checks++;
    if (char_a !== 11'd0) $display("FAIL char_a_row0: char_a=%0d want 0", char_a);
    else n_pass++;
    goto(16 * HT + 1);
    n_checks++;
    if (char_a !== 11'd4) $display("FAIL char_a_row1: char_a=%0d want 4", char_a);
    else n_pass++;
    goto(17 * HT + 9);
    n_checks++;
    if (char_a !== 11'd5) $display("FAIL char_a_cell5: char_a=%0d want 5", char_a);
    else n_pass++;
    goto(17 * HT + 11);
    n_checks++;
    if (font_a !== 12'h051) $display("FAIL font_a: font_a=%h want 051", font_a);
    else n_pass++;
    goto(31 * HT + 32);
    n_checks++;
    if (char_a !== 11'd7) $display("FAIL char_a_last: char_a=%0d want 7", char_a);
    else n_pass++;
    goto(31 * HT + 33);
    n_checks++;
    if (char_a !== 11'd7) $display("FAIL char_a_hold: char_a=%0d want 7", char_a);
    else n_pass++;
    goto(FT);
    n_checks++;
    if (char_a !== 11'd7) $display("FAIL char_a_blank_hold: char_a=%0d want 7", char_a);
    else n_pass++;
    goto(FT + 1);
    n_checks++;
    if (char_a !== 11'd0) $display("FAIL char_a_next_frame: char_a=%0d want 0", char_a);
    else n_pass++;
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'hA5;
    font_zero = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      goto(5 + 8 + i);
      n_checks++;
      if (pixel !== pat[7-i]) $display("FAIL pattern_bit%0d: pixel=%b want %b", i, pixel, pat[7-i]);
      else n_pass++;
    end
    goto(37);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL pattern_blank: pixel=%b want 0", pixel);
    else n_pass++;
  endtask

  task automatic count_frame_pixels(output int ones);
    ones = 0;
    goto(5);
    for (int i = 0; i < FT; i++) begin
      if (pixel === 1'b1) ones++;
      step();
    end
  endtask

  task automatic test_cursor();
    int ones;
    font_zero  = 1'b1;
    cursor_en  = 1'b1;
    cursor_pos = 11'd5;
    do_reset();
    goto(14 * HT + 13);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_wrong_cell: pixel=%b want 0", pixel);
    else n_pass++;
    goto(29 * HT + 13);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_row13: pixel=%b want 0", pixel);
    else n_pass++;
    goto(30 * HT + 12);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_left_edge: pixel=%b want 0", pixel);
    else n_pass++;
    goto(30 * HT + 13);
    n_checks++;
    if (pixel !== 1'b1) $display("FAIL cursor_row14: pixel=%b want 1", pixel);
    else n_pass++;
    goto(30 * HT + 20);
    n_checks++;
    if (pixel !== 1'b1) $display("FAIL cursor_right: pixel=%b want 1", pixel);
    else n_pass++;
    goto(30 * HT + 21);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_right_edge: pixel=%b want 0", pixel);
    else n_pass++;
    goto(31 * HT + 17);
    n_checks++;
    if (pixel !== 1'b1) $display("FAIL cursor_row15: pixel=%b want 1", pixel);
    else n_pass++;
    goto(15 * FT + 30 * HT + 13);
    n_checks++;
    if (pixel !== 1'b1) $display("FAIL cursor_frame15: pixel=%b want 1", pixel);
    else n_pass++;
    goto(16 * FT + 30 * HT + 13);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_frame16: pixel=%b want 0", pixel);
    else n_pass++;
    goto(17 * FT + 31 * HT + 17);
    n_checks++;
    if (pixel !== 1'b0) $display("FAIL cursor_frame17: pixel=%b want 0", pixel);
    else n_pass++;

    do_reset();
    count_frame_pixels(ones);
    n_checks++;
    if (ones != 16) $display("FAIL cursor_count: ones=%0d want 16", ones);
    else n_pass++;

    cursor_pos = 11'd8;
    do_reset();
    count_frame_pixels(ones);
    n_checks++;
    if (ones != 0) $display("FAIL cursor_out_of_range: ones=%0d want 0", ones);
    else n_pass++;

    cursor_pos = 11'd5;
    cursor_en  = 1'b0;
    do_reset();
    count_frame_pixels(ones);
    n_checks++;
    if (ones != 0) $display("FAIL cursor_disabled: ones=%0d want 0", ones);
    else n_pass++;
    font_zero = 1'b0;
  endtask

  task automatic test_mid_reset();
    font_zero = 1'b0;
    do_reset();
    goto(20 * HT + 20);
    n_checks++;
    if (blank !== 1'b0) $display("FAIL midreset_pre: blank=%b want 0", blank);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    n_checks++;
    if (char_a !== 11'd0 || font_a !== 12'd0 || pixel !== 1'b0 || blank !== 1'b1 ||
        hsync !== 1'b1 || vsync !== 1'b0 || frame !== 1'b0)
      $display("FAIL midreset_values: char_a=%0d font_a=%0d pix=%b blank=%b hs=%b vs=%b fr=%b",
               char_a, font_a, pixel, blank, hsync, vsync, frame);
    else n_pass++;
    goto(5);
    n_checks++;
    if (frame !== 1'b1) $display("FAIL midreset_frame: frame=%b want 1", frame);
    else n_pass++;
    goto(40);
    n_checks++;
    if (hsync !== 1'b1) $display("FAIL midreset_hs_before: hsync=%b want 1", hsync);
    else n_pass++;
    goto(41);
    n_checks++;
    if (hsync !== 1'b0) $display("FAIL midreset_hs_start: hsync=%b want 0", hsync);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hsync_blank();
    test_vsync_frame();
    test_char_addr();
    test_pattern();
    test_cursor();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
